pcf8574_i2c_writer: RTL and testbench

- Single-master I2C byte writer that sits directly downstream of the hd44780 controller.
- Each accepted byte is sent as one write transaction to a PCF8574 expander driving the LCD bus: START, address+W, data, STOP.
- hd44780 hands over one expander byte at a time (nibble + RS/RW/EN/backlight bits) and waits on ready.
- Drives SCL/SDA open-drain; the top level maps them onto JC[0]/JC[1].

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/pcf8574_i2c_writer_sync2.sv | 18 +
 rtl/pcf8574_i2c_writer.sv | 165 ++++++++++++++++
 tb/tb_pcf8574_i2c_writer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the PCF8574 I2C byte writer.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_DATA,
    ST_ACK_D,
    ST_STOP
  } i2c_state_t;

  // Expander bit positions as used by the hd44780 controller.
  localparam int unsigned PCF_RS = 0;
  localparam int unsigned PCF_RW = 1;
  localparam int unsigned PCF_EN = 2;
  localparam int unsigned PCF_BL = 3;
  localparam int unsigned PCF_D4 = 4;
  localparam int unsigned PCF_D5 = 5;
  localparam int unsigned PCF_D6 = 6;
  localparam int unsigned PCF_D7 = 7;

  function automatic int unsigned quarter_count(input int unsigned clk_hz,
                                                input int unsigned i2c_hz);
    return clk_hz / (4 * i2c_hz);
  endfunction

endpackage

// File: rtl/pcf8574_i2c_writer_sync2.sv
// Two-flop synchronizer for an open-drain pad readback; resets to the idle-high level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= '1;
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/pcf8574_i2c_writer.sv
// Single-master I2C writer: one START / address+W / data / STOP transaction per accepted byte.
module pcf8574_i2c_writer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned I2C_HZ   = 100_000,
  parameter logic [6:0]  DEV_ADDR = 7'h27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       nack,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int unsigned Q  = quarter_count(CLK_HZ, I2C_HZ);
  localparam int unsigned CW = (Q < 2) ? 1 : $clog2(Q);

  if (Q < 2) begin : g_q_check
    $error("pcf8574_i2c_writer: CLK_HZ/(4*I2C_HZ) must be at least 2");
  end

  i2c_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          flag_q, flag_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          scl_s, sda_s;
  logic          accept, tick, wait_scl, q_end, ph_end, is_bit, is_ack;

  sync2 u_sync_scl (.clk(clk), .rst(rst), .d_i(scl_i), .q_o(scl_s));
  sync2 u_sync_sda (.clk(clk), .rst(rst), .d_i(sda_i), .q_o(sda_s));

  assign is_bit = (state_q == ST_ADDR)  || (state_q == ST_DATA);
  assign is_ack = (state_q == ST_ACK_A) || (state_q == ST_ACK_D);
  assign accept = valid && ready;
  assign tick   = (cnt_q == CW'(Q - 1));
  // Stretching is only honoured on the last clock of the SCL-release quarter,
  // so the synchronizer delay is hidden when the slave does not stretch.
  assign wait_scl = !scl_s && (((is_bit || is_ack) && qtr_q == 2'd2) ||
                               (state_q == ST_STOP && qtr_q == 2'd1));
  assign q_end  = tick && !wait_scl;
  assign ph_end = q_end && (qtr_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: if (ph_end) state_d = ST_ADDR;
      ST_ADDR:  if (ph_end && bit_q == 3'd7) state_d = ST_ACK_A;
      ST_ACK_A: if (ph_end) state_d = flag_q ? ST_STOP : ST_DATA;
      ST_DATA:  if (ph_end && bit_q == 3'd7) state_d = ST_ACK_D;
      ST_ACK_D: if (ph_end) state_d = ST_STOP;
      ST_STOP:  if (ph_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    ready  = 1'b0;
    case (state_q)
      ST_IDLE:  ready = !done_q;
      ST_START: begin
        scl_oe = (qtr_q == 2'd3);
        sda_oe = (qtr_q != 2'd0);
      end
      ST_ADDR, ST_DATA: begin
        scl_oe = !qtr_q[1];
        sda_oe = !shift_q[7];
      end
      ST_ACK_A, ST_ACK_D: scl_oe = !qtr_q[1];
      ST_STOP: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = !qtr_q[1];
      end
      default: ;
    endcase
  end

  assign done = done_q;
  assign nack = nack_q;

  always_comb begin
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    flag_d  = flag_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        cnt_d   = '0;
        qtr_d   = '0;
        bit_d   = '0;
        shift_d = {DEV_ADDR, 1'b0};
        hold_d  = data;
        flag_d  = 1'b0;
      end
    end else begin
      if (q_end) begin
        cnt_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else if (!tick) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (is_ack && q_end && qtr_q == 2'd2) flag_d = flag_q | sda_s;
      if (ph_end) begin
        case (state_q)
          ST_ADDR, ST_DATA: begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
          end
          ST_ACK_A: shift_d = hold_q;
          ST_STOP: begin
            done_d = 1'b1;
            nack_d = flag_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      flag_q  <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      flag_q  <= flag_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pcf8574_i2c_writer.sv
// Bench for pcf8574_i2c_writer: open-drain bus with pull-ups and a behavioural PCF8574 slave.
module tb_pcf8574_i2c_writer;

  localparam int Q       = 10;
  localparam int STRETCH = 37;
  // Slave holds SCL from its fall; the master's own low time plus the q2 window
  // (seen through two flops) absorbs the first 3Q-3 clocks of holding.
  localparam int HOLD    = 3 * Q - 3 + STRETCH;

  logic       clk, rst, valid, ready, done, nack, scl_oe, sda_oe;
  logic [7:0] data;
  logic       sl_scl_low, sl_sda_low, sl_reset;
  logic       ack_a_en, ack_d_en, stretch_en;
  wire        scl_pad = !(scl_oe || sl_scl_low);
  wire        sda_pad = !(sda_oe || sl_sda_low);

  int         checks, failures;
  int         pulses, starts, stops, hold_cnt;
  logic [7:0] addr_cap, data_cap;
  logic       last_nack;

  pcf8574_i2c_writer #(
    .CLK_HZ  (4_000_000),
    .I2C_HZ  (100_000),
    .DEV_ADDR(7'h27)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .data  (data),
    .ready (ready),
    .done  (done),
    .nack  (nack),
    .scl_i (scl_pad),
    .sda_i (sda_pad),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Slave: decodes START/STOP, captures address and data bits on SCL rise,
  // ACKs on request and optionally stretches the 3rd data bit.
  initial begin : slave
    logic prev_scl, prev_sda, cur_scl, cur_sda, in_txn;
    sl_scl_low = 1'b0; sl_sda_low = 1'b0; hold_cnt = 0; in_txn = 1'b0;
    prev_scl = 1'b1; prev_sda = 1'b1;
    forever begin
      @(negedge clk);
      cur_scl = scl_pad;
      cur_sda = sda_pad;
      if (sl_reset) begin
        in_txn = 1'b0; sl_scl_low = 1'b0; sl_sda_low = 1'b0; hold_cnt = 0;
      end else begin
        if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) sl_scl_low = 1'b0;
        end
        if (prev_scl && cur_scl && prev_sda != cur_sda) begin
          if (!cur_sda) begin in_txn = 1'b1; pulses = 0; starts++; end
          else begin in_txn = 1'b0; stops++; end
        end else if (in_txn && !prev_scl && cur_scl) begin
          pulses++;
          if (pulses <= 8) addr_cap = {addr_cap[6:0], cur_sda};
          else if (pulses >= 10 && pulses <= 17) data_cap = {data_cap[6:0], cur_sda};
        end else if (in_txn && prev_scl && !cur_scl) begin
          sl_sda_low = (pulses == 8 && ack_a_en) || (pulses == 17 && ack_d_en);
          if (stretch_en && pulses == 11) begin
            sl_scl_low = 1'b1;
            hold_cnt   = HOLD;
          end
        end
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte through the writer; expectations come from the transaction rules.
  task automatic xfer(input logic [7:0] d, input bit aa, input bit ad, input bit st,
                      input bit keep, input bit b2b);
    int   w, k, exp_lat;
    bit   rdy_bad;
    logic exp_nack;
    ack_a_en = aa; ack_d_en = ad; stretch_en = st;
    starts = 0; stops = 0; pulses = 0; addr_cap = '0; data_cap = '0;
    data  = d;
    valid = 1'b1;
    w = 0;
    while (!ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("ready_wait", ready, 1);
    if (b2b) check("b2b_gap", w, 0);
    @(posedge clk); #1;
    if (!keep) valid = 1'b0;
    check("ready_drop", ready, 0);
    check("nack_hold", nack, last_nack);
    k = 0; rdy_bad = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1; k++;
      if (ready) rdy_bad = 1;
    end
    exp_nack = !aa || !ad;
    exp_lat  = (aa ? 20 : 11) * 4 * Q + 1 + ((st && aa) ? STRETCH : 0);
    check("latency", k + 1, exp_lat);
    check("done", done, 1);
    check("nack", nack, exp_nack);
    check("ready_low", rdy_bad, 0);
    check("addr_byte", addr_cap, 8'h4E);
    if (aa) check("data_byte", data_cap, d);
    check("scl_rises", pulses, aa ? 19 : 10);
    check("start_cnt", starts, 1);
    check("stop_cnt", stops, 1);
    last_nack = exp_nack;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("ready_back", ready, 1);
  endtask

  initial begin : stim
    logic [7:0] d;
    bit         aa, ad;
    checks = 0; failures = 0; last_nack = 1'b0;
    valid = 1'b0; data = '0; sl_reset = 1'b1;
    ack_a_en = 1'b1; ack_d_en = 1'b1; stretch_en = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; sl_reset = 1'b0;
    repeat (2) @(negedge clk);

    xfer(8'hA5, 1, 1, 0, 0, 0);
    xfer(8'h3C, 0, 1, 0, 0, 0);

    // Reset in the middle of the 5th data bit (SCL low quarter).
    d = 8'($urandom);
    ack_a_en = 1'b1; ack_d_en = 1'b1; stretch_en = 1'b0;
    starts = 0; stops = 0;
    data = d; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (14 * 4 * Q + Q + 5 - 1) @(posedge clk);
    #3;
    check("mid_scl_low", scl_oe, 1);
    rst = 1'b1; sl_reset = 1'b1;
    #1;
    check("arst_scl_oe", scl_oe, 0);
    check("arst_sda_oe", sda_oe, 0);
    check("arst_ready", ready, 1);
    check("arst_nack", nack, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; sl_reset = 1'b0;
    last_nack = 1'b0;
    repeat (2) @(negedge clk);
    xfer(8'($urandom), 1, 1, 0, 0, 0);

    xfer(8'($urandom), 1, 1, 1, 0, 0);

    xfer(8'h01, 1, 1, 0, 1, 0);
    xfer(8'h02, 1, 1, 0, 1, 1);
    xfer(8'h03, 1, 1, 0, 0, 1);

    xfer(8'hFF, 1, 0, 0, 0, 0);
    xfer(8'($urandom), 1, 1, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      d  = 8'($urandom);
      aa = ($urandom_range(0, 3) != 0);
      ad = ($urandom_range(0, 1) != 0);
      xfer(d, aa, ad, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
